muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multiply/divide responder for the EX stage: accepts a one-cycle start request with an op and two
//  operands, holds busy for a fixed latency, then commits the 64-bit result to architectural HI/LO.
//  Sits beside the ALU in ex; its busy output and the ex start strobe feed the hazard unit,
//  which stalls MFHI/MFLO and further mult/div ops until busy drops.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   single clock; all state updates on rising edge
//  reset   in   1   synchronous, active-high; clears all state
//  start   in   1   one-cycle request strobe from ex; sampled only when busy==0
//  op      in   3   MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO (others = no-op)
//  a       in   32  rs operand (dividend / multiplicand / MTHI,MTLO source)
//  b       in   32  rt operand (divisor / multiplier)
//  busy    out  1   registered; high while an operation is in flight
//  hi      out  32  architectural HI register
//  lo      out  32  architectural LO register
// BEHAVIOUR
//  Reset: busy=0, hi=0, lo=0, counter=0, pending result discarded. Reset wins over start on same edge.
//  States: IDLE, RUN. IDLE + start + MULT/MULTU/DIV/DIVU -> RUN, counter loaded with N-1
//   (N=MULT_CYCLES or DIV_CYCLES); operands/result latched into pending regs at that edge.
//  RUN: busy=1; counter decrements each edge; at the edge where counter==0, hi/lo <= pending, -> IDLE.
//  Timing: start sampled at edge E0 -> busy=1 for exactly N cycles after E0; hi/lo carry the new
//   value in the same cycle busy first reads 0 (MFHI issued then reads the new value).
//  MTHI/MTLO: start in IDLE writes a to hi (resp. lo) at the next edge; busy stays 0; other reg untouched.
//  start while busy (any op): ignored, no state change. Hazard unit guarantees no such start.
//  Unknown op with start: no-op, stays IDLE.
//  Arithmetic: MULT {hi,lo}=signed a*b; MULTU unsigned a*b; full 64-bit product.
//   DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend (a).
//   DIVU: unsigned quotient/remainder.
//   b==0 for DIV/DIVU: busy cycle still runs for DIV_CYCLES; hi/lo left unchanged at commit.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  Operands a/b may change freely after the start edge; only latched values are used.
//  No output depends combinationally on any input.
// STRUCTURE
//  Shared header muldiv_defs.v: 3-bit op encodings MD_MULT..MD_MTLO, MD_NOP; state encodings.
//  One sub-module: muldiv_core -- combinational 32x32 signed/unsigned multiply and divide
//   (incl. div-by-zero and overflow rules) returning {hi,lo} plus a valid flag (0 on div-by-zero).
//  muldiv_unit owns the FSM, counter, pending regs and HI/LO.
// TESTING
//  1 reset held 2 cycles, then idle -> busy=0, hi=0, lo=0; reassert reset during RUN -> same next edge.
//  2 MULT a=0xFFFFFFFE(-2) b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
//    MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//  3 DIV a=-7 b=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU 7/2 -> lo=3, hi=1.
//  4 DIV b=0 after MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged;
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5 start MULT, then start DIV on cycle 3 of RUN -> ignored; MULT result commits after 5 cycles, busy then 0.
//  6 MTHI a=0xDEADBEEF in IDLE -> hi updated next edge, busy never rises, lo unchanged;
//    back-to-back MULT right after busy falls -> accepted, busy 5 more cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the {hi,lo} result payload.
package muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  // 3-bit operation codes presented on the op port
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP   = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // 64-bit result as it lands in HI/LO
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

endpackage : muldiv_unit_pkg

// File: rtl/muldiv_core.sv
// Combinational 32x32 multiply/divide datapath.
// Ports:
//   op    in  3   operation code (only MULT/MULTU/DIV/DIVU produce a valid result)
//   a     in  32  multiplicand / dividend
//   b     in  32  multiplier / divisor
//   res   out 64  {hi,lo}: full product, or {remainder,quotient}
//   valid out 1   result should be committed (0 on divide-by-zero or non-arith op)
module muldiv_core
  import muldiv_unit_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output md_result_t      res,
  output logic            valid
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic              div_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   quo_u;
  logic [XLEN-1:0]   rem_u;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product
  assign prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
  assign div_signed = (op == MD_DIV);
  assign a_neg      = div_signed & a[XLEN-1];
  assign b_neg      = div_signed & b[XLEN-1];
  assign mag_a      = a_neg ? (~a + XLEN'(1)) : a;
  assign mag_b      = b_neg ? (~b + XLEN'(1)) : b;
  // Keep the divider free of a zero divisor; the result is discarded in that case
  assign divisor    = (b == '0) ? XLEN'(1) : mag_b;
  assign quo_u      = mag_a / divisor;
  assign rem_u      = mag_a % divisor;
  assign quo        = (a_neg ^ b_neg) ? (~quo_u + XLEN'(1)) : quo_u;
  assign rem        = a_neg ? (~rem_u + XLEN'(1)) : rem_u;

  // Result select
  always_comb begin
    res   = '0;
    valid = 1'b0;
    case (op)
      MD_MULT: begin
        res   = md_result_t'(prod_s);
        valid = 1'b1;
      end
      MD_MULTU: begin
        res   = md_result_t'(prod_u);
        valid = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        res.hi = rem;
        res.lo = quo;
        valid  = (b != '0);
      end
      default: begin
        res   = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule : muldiv_core

// File: rtl/muldiv_unit.sv
// Multiply/divide responder for the EX stage. Accepts a one-cycle start,
// holds busy for a fixed latency, then commits the result to HI/LO.
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   synchronous active-high reset
//   start  in  1   request strobe, only sampled while idle
//   op     in  3   operation code (md_op_e)
//   a      in  32  rs operand
//   b      in  32  rt operand
//   busy   out 1   operation in flight (registered)
//   hi     out 32  architectural HI
//   lo     out 32  architectural LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_result_t      pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            busy_q;

  md_result_t      core_res;
  logic            core_valid;

  // Result is computed from the live operands and latched at the start edge
  muldiv_core u_core (
    .op    (op),
    .a     (a),
    .b     (b),
    .res   (core_res),
    .valid (core_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= (state_d == ST_RUN);
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_d      = ST_RUN;
              cnt_d        = CNT_W'(MULT_CYCLES - 1);
              pend_d       = core_res;
              pend_valid_d = core_valid;
            end
            MD_DIV, MD_DIVU: begin
              state_d      = ST_RUN;
              cnt_d        = CNT_W'(DIV_CYCLES - 1);
              pend_d       = core_res;
              pend_valid_d = core_valid;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        // Starts are ignored here; the hazard unit keeps them away
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (pend_valid_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit with a queue-based scoreboard.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] mhi;
  logic [31:0] mlo;
  int          bcnt;

  muldiv_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: predict the HI/LO outcome of an accepted op
  task automatic predict(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    exp_t        e;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULT: begin
        p = 64'(sx * sy);
        mhi = p[63:32]; mlo = p[31:0];
        e.cyc = MULT_CYCLES;
      end
      MD_MULTU: begin
        p = 64'(x) * 64'(y);
        mhi = p[63:32]; mlo = p[31:0];
        e.cyc = MULT_CYCLES;
      end
      MD_DIV: begin
        if (y != 0) begin
          q = sx / sy; r = sx % sy;
          mlo = q[31:0]; mhi = r[31:0];
        end
        e.cyc = DIV_CYCLES;
      end
      MD_DIVU: begin
        if (y != 0) begin
          mlo = x / y; mhi = x % y;
        end
        e.cyc = DIV_CYCLES;
      end
      MD_MTHI: begin mhi = x; e.cyc = 0; end
      MD_MTLO: begin mlo = x; e.cyc = 0; end
      default: e.cyc = 0;
    endcase
    e.hi = mhi;
    e.lo = mlo;
    if (e.cyc != 0) sb_q.push_back(e);
  endtask

  // Drive one start strobe; accept says whether the DUT should take it
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit accept);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (accept) predict(o, x, y);
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'(MD_NOP); a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: measure each busy window and compare HI/LO when it closes
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else if (busy) begin
      bcnt++;
    end else if (bcnt > 0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_commit", 64'(bcnt), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("busy_len", 64'(bcnt), 64'(e.cyc));
        chk("hilo", {hi, lo}, {e.hi, e.lo});
      end
      bcnt = 0;
    end
  end

  initial begin
    checks = 0; errors = 0; bcnt = 0;
    mhi = '0; mlo = '0;
    reset = 1'b1; start = 1'b0; op = 3'(MD_NOP); a = '0; b = '0;

    // 1: reset for two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // 2: MULT / MULTU
    issue(3'(MD_MULT), 32'hFFFF_FFFE, 32'd3, 1'b1);
    chk("mult_busy_rise", 64'(busy), 64'd1);
    wait_idle();
    chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'(MD_MULTU), 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle();
    chk("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // 3: DIV / DIVU
    issue(3'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'(MD_DIVU), 32'd7, 32'd2, 1'b1);
    wait_idle();
    chk("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);

    // 4: divide by zero leaves HI/LO; overflow case
    issue(3'(MD_MTHI), 32'h1234, 32'd0, 1'b1);
    issue(3'(MD_MTLO), 32'h5678, 32'd0, 1'b1);
    issue(3'(MD_DIV), 32'd99, 32'd0, 1'b1);
    wait_idle();
    chk("div0_const", {hi, lo}, 64'h0000_1234_0000_5678);
    issue(3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("divovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // 5: start while busy is ignored
    issue(3'(MD_MULT), 32'd1000, 32'hFFFF_FFF6, 1'b1);
    @(negedge clk);
    issue(3'(MD_DIV), 32'd50, 32'd7, 1'b0);
    wait_idle();
    chk("ignore_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_D8F0);
    @(negedge clk);
    chk("ignore_busy_low", 64'(busy), 64'd0);

    // 6: MTHI in idle, then back-to-back MULT
    issue(3'(MD_MTHI), 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_hilo", {hi, lo}, {32'hDEAD_BEEF, mlo});
    issue(3'(MD_NOP), 32'h5555_5555, 32'd1, 1'b1);
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_hilo", {hi, lo}, {mhi, mlo});
    issue(3'(MD_MULTU), 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_idle();
    issue(3'(MD_MULT), 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    chk("b2b_busy_rise", 64'(busy), 64'd1);
    wait_idle();

    // Random mix
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      y = (i % 4 == 3) ? 32'd0 : $urandom;
      issue(o, x, y, 1'b1);
      wait_idle();
    end

    // 1b: reset during RUN
    issue(3'(MD_DIV), 32'd100, 32'd3, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    mhi = '0; mlo = '0;
    chk("rst_run_busy", 64'(busy), 64'd0);
    chk("rst_run_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DIV_CYCLES + 2) @(negedge clk);
    chk("rst_run_stay_idle", {63'd0, busy}, 64'd0);
    chk("rst_run_stay_zero", {hi, lo}, 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_muldiv_unit
